// File: rtl/core_mc_if.sv
// Memory port between core_mc and the memory/MMIO arbiter: a single request
// held until acknowledged, with read data valid in the ack cycle.
interface core_mc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/core_mc.sv
// Multicycle 16-bit-instruction core: fetch / decode / execute over one
// variable-latency req/ack memory port, with branch, HALT and a register file.
module core_mc #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 21,
    parameter int                NUM_REGS = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h2800)
) (
    input  logic              clk,
    input  logic              rst,
    core_mc_if.master         bus,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_AND    = 6'b000000;
    localparam logic [5:0] OP_OR     = 6'b000001;
    localparam logic [5:0] OP_NOT    = 6'b000010;
    localparam logic [5:0] OP_XOR    = 6'b000011;
    localparam logic [5:0] OP_ADDU   = 6'b000100;
    localparam logic [5:0] OP_SUBU   = 6'b000110;
    localparam logic [5:0] OP_JMP    = 6'b100000;
    localparam logic [5:0] OP_LOADL  = 6'b100100;
    localparam logic [5:0] OP_WRITEL = 6'b101100;
    localparam logic [5:0] OP_BEQZ   = 6'b110100;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    function automatic logic is_alu(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADDU, OP_SUBU: is_alu = 1'b1;
            default:                                         is_alu = 1'b0;
        endcase
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       ir_r;
    logic [ADDR_W-1:0] addr_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              halted_r;
    // Entries at or above NUM_REGS are never written, so they always read 0.
    logic [DATA_W-1:0] regs_r [32];

    logic [5:0]        op_s;
    logic [5:0]        fetch_op_s;
    logic [4:0]        ra_idx_s;
    logic [4:0]        rb_idx_s;
    logic              ra_ok_s;
    logic [DATA_W-1:0] ra_val_s;
    logic [DATA_W-1:0] rb_val_s;
    logic [DATA_W-1:0] alu_s;
    logic [20:0]       addr_full_s;
    logic [ADDR_W-1:0] pc_inc_s;

    // Decode of the latched instruction, operand read and ALU result.
    always_comb begin
        op_s        = ir_r[15:10];
        ra_idx_s    = ir_r[9:5];
        rb_idx_s    = ir_r[4:0];
        fetch_op_s  = bus.mem_rdata[15:10];
        ra_ok_s     = (int'(ra_idx_s) < NUM_REGS);
        ra_val_s    = regs_r[ra_idx_s];
        rb_val_s    = regs_r[rb_idx_s];
        addr_full_s = {ir_r[4:0], bus.mem_rdata[15:0]};
        pc_inc_s    = pc_r + ADDR_W'(1);
        case (op_s)
            OP_AND:  alu_s = ra_val_s & rb_val_s;
            OP_OR:   alu_s = ra_val_s | rb_val_s;
            OP_NOT:  alu_s = ~rb_val_s;
            OP_XOR:  alu_s = ra_val_s ^ rb_val_s;
            OP_ADDU: alu_s = ra_val_s + rb_val_s;
            OP_SUBU: alu_s = ra_val_s - rb_val_s;
            default: alu_s = ra_val_s;
        endcase
    end

    // Sequencer: every output is a flop updated on the transition into its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            pc_r        <= RESET_PC;
            ir_r        <= 16'h0000;
            addr_r      <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            halted_r    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r    <= S_F1;
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= pc_r;
                end
                S_F1: begin
                    if (bus.mem_ack) begin
                        ir_r <= bus.mem_rdata[15:0];
                        pc_r <= pc_inc_s;
                        if (fetch_op_s == OP_HALT) begin
                            state_r   <= S_HALT;
                            mem_req_r <= 1'b0;
                            halted_r  <= 1'b1;
                        end else if (fetch_op_s[5]) begin
                            state_r    <= S_F2;
                            mem_addr_r <= pc_inc_s;
                        end else if (is_alu(fetch_op_s)) begin
                            state_r   <= S_EX;
                            mem_req_r <= 1'b0;
                        end else begin
                            // One-word NOP: keep the request up for the next word.
                            mem_addr_r <= pc_inc_s;
                        end
                    end
                end
                S_F2: begin
                    if (bus.mem_ack) begin
                        addr_r    <= addr_full_s[ADDR_W-1:0];
                        pc_r      <= pc_inc_s;
                        state_r   <= S_EX;
                        mem_req_r <= 1'b0;
                    end
                end
                S_EX: begin
                    state_r    <= S_F1;
                    mem_req_r  <= 1'b1;
                    mem_addr_r <= pc_r;
                    case (op_s)
                        OP_JMP: begin
                            pc_r       <= addr_r;
                            mem_addr_r <= addr_r;
                        end
                        OP_BEQZ: begin
                            if (ra_val_s == '0) begin
                                pc_r       <= addr_r;
                                mem_addr_r <= addr_r;
                            end
                        end
                        OP_LOADL, OP_WRITEL: begin
                            state_r     <= S_MEM;
                            mem_addr_r  <= addr_r;
                            mem_we_r    <= (op_s == OP_WRITEL);
                            mem_wdata_r <= ra_val_s;
                        end
                        default: begin
                            if (is_alu(op_s) && ra_ok_s) begin
                                regs_r[ra_idx_s] <= alu_s;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ack) begin
                        if (!mem_we_r && ra_ok_s) begin
                            regs_r[ra_idx_s] <= bus.mem_rdata;
                        end
                        state_r    <= S_F1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= pc_r;
                    end
                end
                S_HALT: begin
                    mem_req_r <= 1'b0;
                    halted_r  <= 1'b1;
                end
                default: begin
                    state_r   <= S_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign halted        = halted_r;
    assign dbg_pc        = pc_r;

endmodule

// File: tb/tb_core_mc.sv
// Scoreboard bench for core_mc: directed programs, a memory responder with
// configurable ack delay, and a monitor that checks every completed bus cycle.
module tb_core_mc;
    localparam int DW = 16;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          halted;
    logic [AW-1:0] dbg_pc;

    core_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    core_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .RESET_PC(21'h2800)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .halted (halted),
        .dbg_pc (dbg_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          exp_q[$];
    logic [DW-1:0] mem [int];
    int            start_cyc [int];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            delay = 0;
    bit            ack_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic er(input int a);
        exp_q.push_back({1'b0, AW'(a), 16'h0000});
    endtask

    task automatic er_n(input int a, input int n);
        for (int i = 0; i < n; i++) er(a + i);
    endtask

    task automatic ew(input int a, input logic [DW-1:0] d);
        exp_q.push_back({1'b1, AW'(a), d});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory responder: acks each request after 'delay' wait cycles.
    initial begin
        bit   pending;
        int   wcnt;
        txn_t held;
        pending = 1'b0;
        wcnt = 0;
        held = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (ack_force) begin
                bus.mem_ack = 1'b1;
                pending = 1'b0;
            end else if (bus.mem_req) begin
                if (pending) begin
                    checks++;
                    if (held != {bus.mem_we, bus.mem_addr, bus.mem_wdata}) begin
                        errors++;
                        $display("FAIL req_stable: got %h expected %h",
                                 {bus.mem_we, bus.mem_addr, bus.mem_wdata}, held);
                    end
                end else begin
                    pending = 1'b1;
                    wcnt = 0;
                    held = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                    start_cyc[int'(bus.mem_addr)] = cyc;
                end
                if (wcnt >= delay) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        mem[int'(bus.mem_addr)] = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : 16'h0000;
                    end
                    pending = 1'b0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                pending = 1'b0;
            end
        end
    end

    // Monitor: every completed bus cycle is compared against the expected queue.
    initial begin
        txn_t obs;
        txn_t e;
        forever begin
            @(posedge clk);
            if (!rst && bus.mem_req && bus.mem_ack) begin
                obs = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0000};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h expected none",
                             obs.we, obs.addr, obs.data);
                end else begin
                    e = exp_q.pop_front();
                    if (obs != e) begin
                        errors++;
                        $display("FAIL bus_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                                 obs.we, obs.addr, obs.data, e.we, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        start_cyc.delete();
        rst = 1'b1;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_dbg_pc", 32'(dbg_pc), 32'h2800);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        ack_force = 1'b0;
        chk("first_fetch_req", 32'(bus.mem_req), 32'h1);
        chk("first_fetch_addr", 32'(bus.mem_addr), 32'h2800);
    endtask

    task automatic run_until_halt(input string name, input int limit);
        int n;
        n = 0;
        while (!halted && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_halted"}, 32'(halted), 32'h1);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic load_prog1();
        mem.delete();
        mem[32'h2800] = 16'h9020; mem[32'h2801] = 16'h3000;
        mem[32'h2802] = 16'h9040; mem[32'h2803] = 16'h3001;
        mem[32'h2804] = 16'h1022;
        mem[32'h2805] = 16'hB020; mem[32'h2806] = 16'h3002;
        mem[32'h2807] = 16'hFC00;
        mem[32'h3000] = 16'h0003; mem[32'h3001] = 16'h0004;
        er_n(32'h2800, 2); er(32'h3000);
        er_n(32'h2802, 2); er(32'h3001);
        er_n(32'h2804, 3); ew(32'h3002, 16'h0007);
        er(32'h2807);
    endtask

    initial begin
        int n;

        // Program 1, ack in the first request cycle.
        delay = 0;
        load_prog1();
        do_reset();
        run_until_halt("p1", 200);
        chk("p1_result", 32'(mem[32'h3002]), 32'h0007);
        chk("p1_dbg_pc", 32'(dbg_pc), 32'h2808);
        chk("p1_loadl_cycles", 32'(start_cyc[32'h2802] - start_cyc[32'h2800]), 32'd4);
        chk("p1_addu_cycles", 32'(start_cyc[32'h2805] - start_cyc[32'h2804]), 32'd2);

        // Subtract wrap and bitwise NOT.
        mem.delete();
        mem[32'h2800] = 16'h9020; mem[32'h2801] = 16'h3010;
        mem[32'h2802] = 16'h9040; mem[32'h2803] = 16'h3011;
        mem[32'h2804] = 16'h1822;
        mem[32'h2805] = 16'hB020; mem[32'h2806] = 16'h3012;
        mem[32'h2807] = 16'h0861;
        mem[32'h2808] = 16'hB060; mem[32'h2809] = 16'h3013;
        mem[32'h280A] = 16'hFC00;
        mem[32'h3010] = 16'h0000; mem[32'h3011] = 16'h0001;
        er_n(32'h2800, 2); er(32'h3010);
        er_n(32'h2802, 2); er(32'h3011);
        er_n(32'h2804, 3); ew(32'h3012, 16'hFFFF);
        er_n(32'h2807, 3); ew(32'h3013, 16'h0000);
        er(32'h280A);
        do_reset();
        run_until_halt("p2", 200);
        chk("p2_dbg_pc", 32'(dbg_pc), 32'h280B);

        // Program 1 again with three wait cycles per request.
        delay = 3;
        load_prog1();
        do_reset();
        run_until_halt("p3", 400);
        chk("p3_result", 32'(mem[32'h3002]), 32'h0007);
        chk("p3_addu_cycles", 32'(start_cyc[32'h2805] - start_cyc[32'h2804]), 32'd5);
        chk("p3_loadl_cycles", 32'(start_cyc[32'h2802] - start_cyc[32'h2800]), 32'd13);

        // JMP to the top of the address space, then pc wraps to 0.
        delay = 0;
        mem.delete();
        mem[32'h2800] = 16'h801F; mem[32'h2801] = 16'hFFFF;
        mem[32'h1FFFFF] = 16'h1400;
        mem[32'h0] = 16'hFC00;
        er_n(32'h2800, 2); er(32'h1FFFFF); er(32'h0);
        do_reset();
        run_until_halt("p4", 200);
        chk("p4_dbg_pc", 32'(dbg_pc), 32'h1);
        chk("p4_jmp_cycles", 32'(start_cyc[32'h1FFFFF] - start_cyc[32'h2800]), 32'd3);

        // BEQZ taken with r4=0, then not taken with r4=5.
        mem.delete();
        mem[32'h2800] = 16'hD080; mem[32'h2801] = 16'h2900;
        mem[32'h2900] = 16'h9080; mem[32'h2901] = 16'h3020;
        mem[32'h2902] = 16'hD080; mem[32'h2903] = 16'h2A00;
        mem[32'h2904] = 16'hFC00;
        mem[32'h2A00] = 16'hFC00;
        mem[32'h3020] = 16'h0005;
        er_n(32'h2800, 2); er_n(32'h2900, 2); er(32'h3020); er_n(32'h2902, 3);
        do_reset();
        run_until_halt("p5", 200);
        chk("p5_dbg_pc", 32'(dbg_pc), 32'h2905);
        chk("p5_beqz_cycles", 32'(start_cyc[32'h2900] - start_cyc[32'h2800]), 32'd3);

        // Reset during an outstanding LOADL, late ack, then HALT.
        delay = 4;
        mem.delete();
        mem[32'h2800] = 16'h90A0; mem[32'h2801] = 16'h3030;
        mem[32'h3030] = 16'h1234;
        er_n(32'h2800, 2);
        do_reset();
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 21'h3030) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("p6_reached_loadl", 32'(bus.mem_req && bus.mem_addr == 21'h3030), 32'h1);
        chk("p6_queue_before_abort", 32'(exp_q.size()), 32'h0);
        delay = 0;
        mem[32'h2800] = 16'hB0A0; mem[32'h2801] = 16'h3031;
        mem[32'h2802] = 16'hFC00;
        er_n(32'h2800, 2); ew(32'h3031, 16'h0000); er(32'h2802);
        ack_force = 1'b1;
        do_reset();
        run_until_halt("p6", 200);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("p6_halt_req_low", 32'(bus.mem_req), 32'h0);
            chk("p6_halt_held", 32'(halted), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
